nf_wb_arb: RTL and testbench

NF_WB_ARB -- requirements
Module: nf_wb_arb

---
 rtl/nf_wb_arb_if.sv | 26 ++
 rtl/nf_wb_arb.sv | 63 ++++++
 tb/tb_nf_wb_arb.sv | 137 +++++++++++++
 3 files changed

// File: rtl/nf_wb_arb_if.sv
// nf_wb_arb_if: ALU/load-return write-back and register-file port bundle for nf_wb_arb
interface nf_wb_arb_if #(parameter int DEPTH = 2);
  logic                    alu_we;
  logic [4:0]              alu_wa;
  logic [31:0]             alu_wd;
  logic                    lsu_vld;
  logic [4:0]              lsu_wa;
  logic [31:0]             lsu_wd;
  logic                    lsu_rdy;
  logic [4:0]              wa3;
  logic [31:0]             wd3;
  logic                    we3;
  logic [4:0]              ra1;
  logic [4:0]              ra2;
  logic                    pend1;
  logic                    pend2;
  logic [$clog2(DEPTH):0]  occ;
  modport master (
    output alu_we, alu_wa, alu_wd, lsu_vld, lsu_wa, lsu_wd, ra1, ra2,
    input  lsu_rdy, wa3, wd3, we3, pend1, pend2, occ
  );
  modport slave (
    input  alu_we, alu_wa, alu_wd, lsu_vld, lsu_wa, lsu_wd, ra1, ra2,
    output lsu_rdy, wa3, wd3, we3, pend1, pend2, occ
  );
endinterface

// File: rtl/nf_wb_arb.sv
// nf_wb_arb: register-file write-port arbiter, ALU priority with a FIFO for load returns.
// Optional macro NF_WB_BYPASS_EN lets a load write through when the buffer is empty and ALU idle.
module nf_wb_arb #(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  nf_wb_arb_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [4:0]     wa_q [DEPTH];
  logic [31:0]    wd_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [AW-1:0]  rd, wr;
  logic [CW-1:0]  cnt;
  logic           alu_v, rdy, byp, pop, push, p1, p2;
  assign alu_v = !rst && bus.alu_we && bus.alu_wa != 5'd0;
  assign rdy   = !rst && cnt < CW'(DEPTH);
  assign pop   = !rst && !alu_v && cnt != '0;
`ifdef NF_WB_BYPASS_EN
  assign byp   = !rst && !alu_v && cnt == '0 && bus.lsu_vld && bus.lsu_wa != 5'd0;
`else
  assign byp   = 1'b0;
`endif
  // zero-address loads complete the handshake but are dropped here
  assign push  = rdy && bus.lsu_vld && bus.lsu_wa != 5'd0 && !byp;
  assign bus.lsu_rdy = rdy;
  assign bus.occ     = cnt;
  assign bus.we3     = alu_v || pop || byp;
  assign bus.wa3     = alu_v ? bus.alu_wa : pop ? wa_q[rd] : byp ? bus.lsu_wa : 5'd0;
  assign bus.wd3     = alu_v ? bus.alu_wd : pop ? wd_q[rd] : byp ? bus.lsu_wd : 32'd0;
  always_comb begin
    p1 = 1'b0;
    p2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      p1 = p1 | (vld_q[i] && wa_q[i] == bus.ra1);
      p2 = p2 | (vld_q[i] && wa_q[i] == bus.ra2);
    end
  end
  assign bus.pend1 = !rst && bus.ra1 != 5'd0 && p1;
  assign bus.pend2 = !rst && bus.ra2 != 5'd0 && p2;
  always_ff @(posedge clk) begin
    if (rst) begin
      rd    <= '0;
      wr    <= '0;
      cnt   <= '0;
      vld_q <= '0;
    end else begin
      if (push) begin
        wa_q[wr]  <= bus.lsu_wa;
        wd_q[wr]  <= bus.lsu_wd;
        vld_q[wr] <= 1'b1;
        wr        <= wr + 1'b1;
      end
      if (pop) begin
        vld_q[rd] <= 1'b0;
        rd        <= rd + 1'b1;
      end
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_nf_wb_arb.sv
// tb_nf_wb_arb: directed plus randomized checks of nf_wb_arb against a queue-based write-back model
module tb_nf_wb_arb;
  localparam int DEPTH = 2;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   accepted = 1'b0;
  logic [36:0] q[$];
  nf_wb_arb_if #(.DEPTH(DEPTH)) bus ();
  nf_wb_arb #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // one clock: compare outputs at negedge against the model, then advance the model at the edge
  task automatic cycle();
    bit av, by, rdy, acc, ewe, e1, e2;
    logic [4:0]  ewa;
    logic [31:0] ewd;
    @(negedge clk);
    rdy = !rst && q.size() < DEPTH;
    av  = !rst && bus.alu_we && bus.alu_wa != 0;
    by  = 1'b0;
`ifdef NF_WB_BYPASS_EN
    by  = !rst && !av && q.size() == 0 && bus.lsu_vld && bus.lsu_wa != 0;
`endif
    ewe = 1'b0; ewa = 5'd0; ewd = 32'd0;
    if (av) begin ewe = 1'b1; ewa = bus.alu_wa; ewd = bus.alu_wd; end
    else if (!rst && q.size() > 0) begin ewe = 1'b1; ewa = q[0][36:32]; ewd = q[0][31:0]; end
    else if (by) begin ewe = 1'b1; ewa = bus.lsu_wa; ewd = bus.lsu_wd; end
    e1 = 1'b0; e2 = 1'b0;
    foreach (q[i]) begin
      if (q[i][36:32] == bus.ra1) e1 = 1'b1;
      if (q[i][36:32] == bus.ra2) e2 = 1'b1;
    end
    e1 = e1 && !rst && bus.ra1 != 0;
    e2 = e2 && !rst && bus.ra2 != 0;
    chk("we3",     32'(bus.we3),     32'(ewe));
    chk("wa3",     32'(bus.wa3),     32'(ewa));
    chk("wd3",     bus.wd3,          ewd);
    chk("lsu_rdy", 32'(bus.lsu_rdy), 32'(rdy));
    chk("occ",     32'(bus.occ),     32'(q.size()));
    chk("pend1",   32'(bus.pend1),   32'(e1));
    chk("pend2",   32'(bus.pend2),   32'(e2));
    acc = bus.lsu_vld && rdy;
    accepted = acc;
    @(posedge clk);
    if (rst) q.delete();
    else begin
      if (!av && q.size() > 0) void'(q.pop_front());
      if (acc && bus.lsu_wa != 0 && !by) q.push_back({bus.lsu_wa, bus.lsu_wd});
    end
    #1;
  endtask
  task automatic load(input logic [4:0] wa, input logic [31:0] wd);
    bus.lsu_vld = 1'b1; bus.lsu_wa = wa; bus.lsu_wd = wd;
    accepted = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (accepted) break;
    end
    if (!accepted) chk("load_timeout", 32'd0, 32'd1);
    bus.lsu_vld = 1'b0;
  endtask
  task automatic alu(input bit we, input logic [4:0] wa, input logic [31:0] wd);
    bus.alu_we = we; bus.alu_wa = wa; bus.alu_wd = wd;
  endtask
  initial begin
    rst = 1'b1;
    alu(1'b1, 5'd5, 32'h5);
    bus.lsu_vld = 1'b1; bus.lsu_wa = 5'd1; bus.lsu_wd = 32'h11;
    bus.ra1 = 5'd0; bus.ra2 = 5'd0;
    @(posedge clk); #1;
    cycle(); cycle();
    rst = 1'b0; alu(1'b0, 5'd0, 32'd0); bus.lsu_vld = 1'b0;
    cycle();
    // ALU priority over a buffered load
    load(5'd3, 32'hAAAA_0000);
    alu(1'b1, 5'd4, 32'h1234);
    repeat (3) cycle();
    alu(1'b0, 5'd0, 32'd0);
    repeat (2) cycle();
    // full buffer under continuous ALU traffic
    alu(1'b1, 5'd4, 32'h1234);
    load(5'd6, 32'h66);
    load(5'd7, 32'h77);
    bus.lsu_vld = 1'b1; bus.lsu_wa = 5'd8; bus.lsu_wd = 32'h88;
    repeat (2) cycle();
    chk("full_hold", 32'(accepted), 32'd0);
    alu(1'b0, 5'd0, 32'd0);
    load(5'd8, 32'h88);
    repeat (3) cycle();
    // zero register on both sources
    alu(1'b1, 5'd0, 32'hDEAD);
    load(5'd0, 32'hBEEF);
    alu(1'b0, 5'd0, 32'd0);
    cycle();
    // pending lookup
    alu(1'b1, 5'd2, 32'h22);
    load(5'd9, 32'h99);
    bus.ra1 = 5'd9; bus.ra2 = 5'd0;
    cycle();
    alu(1'b0, 5'd0, 32'd0);
    repeat (2) cycle();
    // bypass candidate: empty buffer, no ALU
    load(5'd10, 32'h55);
    repeat (2) cycle();
    // reset while loaded
    alu(1'b1, 5'd1, 32'h1);
    load(5'd11, 32'hB);
    load(5'd12, 32'hC);
    rst = 1'b1;
    cycle();
    rst = 1'b0; alu(1'b0, 5'd0, 32'd0);
    repeat (2) cycle();
    // randomized traffic; a refused load is held until accepted
    for (int n = 0; n < 400; n++) begin
      if (!bus.lsu_vld || accepted) begin
        bus.lsu_vld = 1'($urandom_range(0, 1));
        bus.lsu_wa  = 5'($urandom_range(0, 7));
        bus.lsu_wd  = $urandom;
      end
      alu($urandom_range(0, 2) == 0, 5'($urandom_range(0, 31)), $urandom);
      bus.ra1 = 5'($urandom_range(0, 7));
      bus.ra2 = 5'($urandom_range(0, 7));
      rst = ($urandom_range(0, 99) == 0);
      cycle();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
